// File: rtl/psum_pkg.sv
// Shared definitions for the psum accumulator / special-function unit.
// Holds the FSM encoding, saturation bounds for the default lane width, and a lane-slice helper.
package psum_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int unsigned PSUM_BW_DEF = 16;
    localparam logic [PSUM_BW_DEF-1:0] PSUM_MAX = 16'h7FFF;
    localparam logic [PSUM_BW_DEF-1:0] PSUM_MIN = 16'h8000;

    // Bit offset of lane k inside a packed beat.
    function automatic int unsigned lane_lsb(input int unsigned k, input int unsigned bw);
        return k * bw;
    endfunction

endpackage

// File: rtl/psum_sat_relu.sv
// One psum lane: optional saturating add of the buffered entry, then optional ReLU.
// y = use_b ? sat(a + b) : a, with negative results forced to zero when relu is set.
module psum_sat_relu #(
    parameter int unsigned psum_bw = 16
) (
    input  logic [psum_bw-1:0] a,
    input  logic [psum_bw-1:0] b,
    input  logic               use_b,
    input  logic               relu,
    output logic [psum_bw-1:0] y
);

    localparam logic [psum_bw-1:0] SAT_MAX = {1'b0, {(psum_bw-1){1'b1}}};
    localparam logic [psum_bw-1:0] SAT_MIN = {1'b1, {(psum_bw-1){1'b0}}};

    logic [psum_bw:0]   sum;
    logic [psum_bw-1:0] sat;

    always_comb begin
        sum = {a[psum_bw-1], a};
        if (use_b) begin
            sum = {a[psum_bw-1], a} + {b[psum_bw-1], b};
        end
        // Extra sign bit disagreeing with the top result bit means the add overflowed.
        if (sum[psum_bw] != sum[psum_bw-1]) begin
            sat = sum[psum_bw] ? SAT_MIN : SAT_MAX;
        end else begin
            sat = sum[psum_bw-1:0];
        end
        y = (relu && sat[psum_bw-1]) ? '0 : sat;
    end

endmodule

// File: rtl/psum_accum_sfu.sv
// Consumer end of the MAC-array psum stream: accumulates beats across input-channel tiles
// into a per-position buffer and streams ReLU'd, saturated results out on the final tile.
module psum_accum_sfu
    import psum_pkg::*;
#(
    parameter int unsigned psum_bw = 16,
    parameter int unsigned col     = 8,
    parameter int unsigned depth   = 16,
    parameter int unsigned addr_bw = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [3:0]             num_tiles,
    input  logic                   relu_en,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [col*psum_bw-1:0] in_psum,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [col*psum_bw-1:0] out_data,
    output logic [addr_bw-1:0]     out_addr,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned        DW       = col * psum_bw;
    localparam logic [addr_bw-1:0] PTR_LAST = addr_bw'(depth - 1);

    state_e               state_q;
    logic [addr_bw-1:0]   ptr_q;
    logic [3:0]           tile_q;
    logic [3:0]           last_tile_q;
    logic                 relu_q;
    logic                 in_done_q;
    logic                 out_valid_q;
    logic [DW-1:0]        out_data_q;
    logic [addr_bw-1:0]   out_addr_q;
    logic                 done_q;
    logic [DW-1:0]        buf_q [depth];

    logic [DW-1:0]        sum_d;
    logic [addr_bw-1:0]   ptr_d;
    logic                 accept;
    logic                 out_hs;
    logic                 ptr_last;

    always_comb begin
        in_ready = 1'b0;
        unique case (state_q)
            ST_ACCUM: in_ready = 1'b1;
            ST_DRAIN: in_ready = !in_done_q && (!out_valid_q || out_ready);
            default:  in_ready = 1'b0;
        endcase
    end

    assign accept   = in_valid && in_ready;
    assign out_hs   = out_valid_q && out_ready;
    assign ptr_last = (ptr_q == PTR_LAST);
    assign ptr_d    = ptr_last ? '0 : ptr_q + addr_bw'(1);

    // Tile 0 passes the beat straight through, so stale buffer contents never matter.
    for (genvar k = 0; k < col; k++) begin : g_lane
        psum_sat_relu #(.psum_bw(psum_bw)) u_lane (
            .a     (in_psum[k*psum_bw +: psum_bw]),
            .b     (buf_q[ptr_q][k*psum_bw +: psum_bw]),
            .use_b (tile_q != 4'd0),
            .relu  (relu_q && (state_q == ST_DRAIN)),
            .y     (sum_d[k*psum_bw +: psum_bw])
        );
    end

    always_ff @(posedge clk) begin
        if (reset_n && accept && (state_q == ST_ACCUM)) begin
            buf_q[ptr_q] <= sum_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            tile_q      <= '0;
            last_tile_q <= '0;
            relu_q      <= 1'b0;
            in_done_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        ptr_q       <= '0;
                        tile_q      <= '0;
                        in_done_q   <= 1'b0;
                        relu_q      <= relu_en;
                        last_tile_q <= (num_tiles == 4'd0) ? 4'd0 : num_tiles - 4'd1;
                        state_q     <= (num_tiles > 4'd1) ? ST_ACCUM : ST_DRAIN;
                    end
                end
                ST_ACCUM: begin
                    if (accept) begin
                        ptr_q <= ptr_d;
                        if (ptr_last) begin
                            tile_q <= tile_q + 4'd1;
                            if ((tile_q + 4'd1) == last_tile_q) begin
                                state_q <= ST_DRAIN;
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    // A new accept reloads the output register in the same cycle it hands off.
                    if (accept) begin
                        out_data_q  <= sum_d;
                        out_addr_q  <= ptr_q;
                        out_valid_q <= 1'b1;
                        ptr_q       <= ptr_d;
                        if (ptr_last) begin
                            in_done_q <= 1'b1;
                        end
                    end else if (out_hs) begin
                        out_valid_q <= 1'b0;
                    end
                    if (out_hs && (out_addr_q == PTR_LAST)) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign done      = done_q;
    assign busy      = (state_q == ST_ACCUM) || (state_q == ST_DRAIN);

endmodule

// File: tb/tb_psum_accum_sfu.sv
// Directed self-checking bench for psum_accum_sfu (col=8, depth=16, psum_bw=16).
`timescale 1ns/1ps
module tb_psum_accum_sfu;

    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    num_tiles = 4'd0;
    logic          relu_en = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_psum = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic [3:0]    out_addr;
    logic          busy;
    logic          done;

    int nchk = 0;
    int nerr = 0;
    int cyc = 0;

    logic [DW-1:0] cap_d[$];
    int            cap_a[$];
    int            hs_last_cyc = -1;
    int            done_cyc = -1;
    int            done_cnt = 0;
    logic          done_busy = 1'b0;
    logic          track_busy = 1'b0;
    int            busy_drop = 0;

    psum_accum_sfu #(.psum_bw(16), .col(8), .depth(16), .addr_bw(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .num_tiles (num_tiles),
        .relu_en   (relu_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_psum   (in_psum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Output monitor: a handshake is seen at the negedge before the edge that completes it.
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            if (done_cyc < 0) begin
                done_cyc  = cyc;
                done_busy = busy;
            end
        end else if (track_busy && done_cnt == 0 && !busy) begin
            busy_drop++;
        end
        if (out_valid && out_ready) begin
            cap_d.push_back(out_data);
            cap_a.push_back(int'(out_addr));
            if (out_addr == 4'd15) hs_last_cyc = cyc;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] lset(input logic [DW-1:0] v, input int k, input logic [15:0] x);
        logic [DW-1:0] r;
        r = v;
        r[k*16 +: 16] = x;
        return r;
    endfunction

    function automatic logic [15:0] lget(input logic [DW-1:0] v, input int k);
        return v[k*16 +: 16];
    endfunction

    task automatic clear_mon();
        cap_d.delete();
        cap_a.delete();
        hs_last_cyc = -1;
        done_cyc    = -1;
        done_cnt    = 0;
        done_busy   = 1'b0;
        track_busy  = 1'b0;
        busy_drop   = 0;
    endtask

    task automatic do_start(input logic [3:0] nt, input logic relu);
        start = 1'b1; num_tiles = nt; relu_en = relu;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [DW-1:0] d);
        int n;
        n = 0;
        in_valid = 1'b1; in_psum = d;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            nchk++; nerr++;
            $display("FAIL send_beat_timeout: in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_psum = '0;
    endtask

    task automatic wait_done(input int lim);
        int n;
        n = 0;
        while (done_cnt == 0 && n < lim) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nchk++; if (in_ready !== 1'b0)  begin nerr++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        nchk++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        nchk++; if (out_data !== '0)    begin nerr++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        nchk++; if (out_addr !== 4'd0)  begin nerr++; $display("FAIL reset_out_addr: got %0d want 0", out_addr); end
        nchk++; if (busy !== 1'b0)      begin nerr++; $display("FAIL reset_busy: got %b want 0", busy); end
        nchk++; if (done !== 1'b0)      begin nerr++; $display("FAIL reset_done: got %b want 0", done); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_relu_single();
        logic [DW-1:0] b, v;
        logic [15:0] e0;
        clear_mon();
        do_start(4'd1, 1'b1);
        nchk++; if (busy !== 1'b1) begin nerr++; $display("FAIL t1_busy_start: got %b want 1", busy); end
        for (int p = 0; p < 16; p++) begin
            b = '0;
            b = lset(b, 0, (p == 0) ? 16'hFFFB : (p == 1) ? 16'd7 : 16'(p));
            b = lset(b, 7, 16'(-p));
            send_beat(b);
        end
        wait_done(100);
        nchk++; if (cap_d.size() !== 16) begin nerr++; $display("FAIL t1_count: got %0d want 16", cap_d.size()); end
        for (int k = 0; k < 16 && k < cap_d.size(); k++) begin
            v  = cap_d[k];
            e0 = (k == 0) ? 16'd0 : (k == 1) ? 16'd7 : 16'(k);
            nchk++; if (cap_a[k] !== k) begin nerr++; $display("FAIL t1_addr[%0d]: got %0d want %0d", k, cap_a[k], k); end
            nchk++; if (lget(v, 0) !== e0) begin nerr++; $display("FAIL t1_lane0[%0d]: got %0d want %0d", k, $signed(lget(v, 0)), $signed(e0)); end
            nchk++; if (lget(v, 7) !== 16'd0) begin nerr++; $display("FAIL t1_lane7_relu[%0d]: got %0d want 0", k, $signed(lget(v, 7))); end
        end
        nchk++; if (done_cnt !== 1) begin nerr++; $display("FAIL t1_done_count: got %0d want 1", done_cnt); end
        nchk++; if (done_cyc !== hs_last_cyc + 1) begin nerr++; $display("FAIL t1_done_timing: got cycle %0d want %0d", done_cyc, hs_last_cyc + 1); end
        nchk++; if (busy !== 1'b0) begin nerr++; $display("FAIL t1_busy_end: got %b want 0", busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_multi_tile();
        logic [DW-1:0] b, v;
        logic [15:0] l3 [3];
        l3[0] = 16'd100; l3[1] = 16'd200; l3[2] = 16'(-50);
        clear_mon();
        do_start(4'd3, 1'b0);
        track_busy = 1'b1;
        nchk++; if (busy !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            nerr++; $display("FAIL t2_accum_entry: busy=%b in_ready=%b out_valid=%b want 1 1 0", busy, in_ready, out_valid);
        end
        for (int t = 0; t < 3; t++) begin
            for (int p = 0; p < 16; p++) begin
                b = '0;
                b = lset(b, 0, 16'(p + t * 10));
                if (p == 0) b = lset(b, 3, l3[t]);
                send_beat(b);
            end
        end
        wait_done(100);
        track_busy = 1'b0;
        nchk++; if (cap_d.size() !== 16) begin nerr++; $display("FAIL t2_count: got %0d want 16", cap_d.size()); end
        if (cap_d.size() > 0) begin
            v = cap_d[0];
            nchk++; if (lget(v, 3) !== 16'd250) begin nerr++; $display("FAIL t2_addr0_lane3: got %0d want 250", $signed(lget(v, 3))); end
        end
        for (int k = 0; k < 16 && k < cap_d.size(); k++) begin
            v = cap_d[k];
            nchk++; if (lget(v, 0) !== 16'(3 * k + 30)) begin nerr++; $display("FAIL t2_lane0[%0d]: got %0d want %0d", k, lget(v, 0), 3 * k + 30); end
        end
        nchk++; if (busy_drop !== 0) begin nerr++; $display("FAIL t2_busy_held: got %0d low cycles want 0", busy_drop); end
        nchk++; if (done_cnt !== 1 || done_busy !== 1'b0) begin nerr++; $display("FAIL t2_done_busy: done_cnt=%0d busy=%b want 1 0", done_cnt, done_busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_saturation();
        logic [DW-1:0] b, v;
        clear_mon();
        do_start(4'd2, 1'b0);
        for (int t = 0; t < 2; t++) begin
            for (int p = 0; p < 16; p++) begin
                b = '0;
                if (p == 0) begin
                    b = lset(b, 0, 16'd30000);
                    b = lset(b, 1, 16'(-30000));
                    b = lset(b, 2, (t == 0) ? 16'd1000 : 16'(-3000));
                end else if (p == 1) begin
                    b = lset(b, 0, (t == 0) ? 16'h7FFF : 16'd0);
                    b = lset(b, 1, (t == 0) ? 16'h8000 : 16'hFFFF);
                end
                send_beat(b);
            end
        end
        wait_done(100);
        nchk++; if (cap_d.size() !== 16) begin nerr++; $display("FAIL t3_count: got %0d want 16", cap_d.size()); end
        if (cap_d.size() >= 2) begin
            v = cap_d[0];
            nchk++; if (lget(v, 0) !== 16'h7FFF) begin nerr++; $display("FAIL t3_pos_sat: got %h want 7fff", lget(v, 0)); end
            nchk++; if (lget(v, 1) !== 16'h8000) begin nerr++; $display("FAIL t3_neg_sat: got %h want 8000", lget(v, 1)); end
            nchk++; if (lget(v, 2) !== 16'hF830) begin nerr++; $display("FAIL t3_no_sat: got %h want f830", lget(v, 2)); end
            v = cap_d[1];
            nchk++; if (lget(v, 0) !== 16'h7FFF) begin nerr++; $display("FAIL t3_max_edge: got %h want 7fff", lget(v, 0)); end
            nchk++; if (lget(v, 1) !== 16'h8000) begin nerr++; $display("FAIL t3_min_edge: got %h want 8000", lget(v, 1)); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] b, v;
        clear_mon();
        do_start(4'd1, 1'b0);
        fork
            begin
                for (int p = 0; p < 16; p++) begin
                    b = '0;
                    b = lset(b, 0, 16'(p + 1));
                    b = lset(b, 5, 16'(100 + p));
                    send_beat(b);
                end
            end
            begin
                int n, ea;
                n = 0;
                while (cap_d.size() < 6 && n < 200) begin @(negedge clk); n++; end
                nchk++; if (n >= 200) begin nerr++; $display("FAIL t4_stall_wait: got %0d outputs want 6", cap_d.size()); end
                @(posedge clk); #1;
                out_ready = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    ea = cap_a.size();
                    nchk++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                        nerr++; $display("FAIL t4_stall_ctrl[%0d]: in_ready=%b out_valid=%b want 0 1", c, in_ready, out_valid);
                    end
                    nchk++; if (int'(out_addr) !== ea || lget(out_data, 0) !== 16'(ea + 1) || lget(out_data, 5) !== 16'(100 + ea)) begin
                        nerr++; $display("FAIL t4_stall_hold[%0d]: addr=%0d lane0=%0d want addr %0d lane0 %0d", c, out_addr, lget(out_data, 0), ea, ea + 1);
                    end
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        wait_done(100);
        nchk++; if (cap_d.size() !== 16) begin nerr++; $display("FAIL t4_count: got %0d want 16", cap_d.size()); end
        for (int k = 0; k < 16 && k < cap_d.size(); k++) begin
            v = cap_d[k];
            nchk++; if (cap_a[k] !== k || lget(v, 0) !== 16'(k + 1) || lget(v, 5) !== 16'(100 + k)) begin
                nerr++; $display("FAIL t4_order[%0d]: addr=%0d lane0=%0d lane5=%0d want %0d %0d %0d", k, cap_a[k], lget(v, 0), lget(v, 5), k, k + 1, 100 + k);
            end
        end
        nchk++; if (done_cnt !== 1) begin nerr++; $display("FAIL t4_done_count: got %0d want 1", done_cnt); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] nine;
        nine = {8{16'd9}};
        clear_mon();
        do_start(4'd3, 1'b0);
        for (int p = 0; p < 20; p++) send_beat({8{16'd50}});
        reset_n = 1'b0;
        @(posedge clk); #1;
        nchk++; if (in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            nerr++; $display("FAIL t5_abort: in_ready=%b busy=%b out_valid=%b want 0 0 0", in_ready, busy, out_valid);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        clear_mon();
        do_start(4'd1, 1'b0);
        for (int p = 0; p < 16; p++) send_beat(nine);
        wait_done(100);
        nchk++; if (cap_d.size() !== 16) begin nerr++; $display("FAIL t5_count: got %0d want 16", cap_d.size()); end
        for (int k = 0; k < 16 && k < cap_d.size(); k++) begin
            nchk++; if (cap_d[k] !== nine || cap_a[k] !== k) begin
                nerr++; $display("FAIL t5_fresh[%0d]: data=%h addr=%0d want %h %0d", k, cap_d[k], cap_a[k], nine, k);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_zero_tiles_restart();
        logic [DW-1:0] b, v;
        clear_mon();
        do_start(4'd0, 1'b0);
        fork
            begin
                for (int p = 0; p < 16; p++) begin
                    b = '0;
                    b = lset(b, 0, 16'(2 * p));
                    b = lset(b, 6, 16'(-p));
                    send_beat(b);
                end
            end
            begin
                int n;
                n = 0;
                while (cap_d.size() < 3 && n < 200) begin @(negedge clk); n++; end
                @(posedge clk); #1;
                do_start(4'd2, 1'b1);
            end
        join
        wait_done(100);
        repeat (20) @(negedge clk);
        nchk++; if (cap_d.size() !== 16) begin nerr++; $display("FAIL t6_count: got %0d want 16", cap_d.size()); end
        nchk++; if (done_cnt !== 1) begin nerr++; $display("FAIL t6_done_count: got %0d want 1", done_cnt); end
        for (int k = 0; k < 16 && k < cap_d.size(); k++) begin
            v = cap_d[k];
            nchk++; if (cap_a[k] !== k || lget(v, 0) !== 16'(2 * k) || lget(v, 6) !== 16'(-k)) begin
                nerr++; $display("FAIL t6_data[%0d]: addr=%0d lane0=%0d lane6=%0d want %0d %0d %0d", k, cap_a[k], lget(v, 0), $signed(lget(v, 6)), k, 2 * k, -k);
            end
        end
        nchk++; if (busy !== 1'b0 || in_ready !== 1'b0) begin nerr++; $display("FAIL t6_idle_after: busy=%b in_ready=%b want 0 0", busy, in_ready); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_relu_single();
        test_multi_tile();
        test_saturation();
        test_backpressure();
        test_reset_mid();
        test_zero_tiles_restart();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
        $finish;
    end

endmodule
